// File: rtl/move_command_queue.sv
// Button-press command queue: merges debounced press pulses into a pending set,
// enqueues one command per cycle by priority into a first-word-fall-through FIFO.
module move_command_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     left_pulse,
  input  logic                     right_pulse,
  input  logic                     rotate_pulse,
  input  logic                     drop_pulse,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_code,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NB = 4;

  // Request bits are indexed by command code: 0 left, 1 right, 2 rotate, 3 drop.
  logic [NB-1:0] pulses;
  logic [NB-1:0] req;
  logic [NB-1:0] sel;
  logic [1:0]    push_code;
  logic          pop;
  logic          push;
  logic          can_push;
  logic [AW-1:0] rd_next;

  logic [NB-1:0] pend_q, pend_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [1:0]    head_q, head_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    mem_q [DEPTH];

  assign pulses = {drop_pulse, rotate_pulse, right_pulse, left_pulse};
  assign req    = pend_q | pulses;

  // Priority select: drop > rotate > left > right.
  always_comb begin
    sel       = '0;
    push_code = 2'd0;
    if (req[3]) begin
      sel       = 4'b1000;
      push_code = 2'd3;
    end else if (req[2]) begin
      sel       = 4'b0100;
      push_code = 2'd2;
    end else if (req[0]) begin
      sel       = 4'b0001;
      push_code = 2'd0;
    end else if (req[1]) begin
      sel       = 4'b0010;
      push_code = 2'd1;
    end
  end

  assign pop      = valid_q & cmd_ready;
  assign can_push = (count_q < CW'(DEPTH)) | pop;
  assign push     = can_push & (|req);
  assign rd_next  = rd_ptr_q + AW'(1);

  always_comb begin
    pend_d   = req;
    ovf_d    = ovf_q | (|(pend_q & pulses));
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push) begin
      pend_d   = req & ~sel;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Registered head keeps cmd_code fall-through while staying a flop output.
    if (pop) begin
      if (count_q == CW'(1)) begin
        head_d = push ? push_code : 2'd0;
      end else begin
        head_d = mem_q[rd_next];
      end
    end else if (count_q == '0) begin
      head_d = push ? push_code : 2'd0;
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = head_q;
  assign cmd_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_move_command_queue.sv
// Self-checking bench for move_command_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_move_command_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       left_pulse, right_pulse, rotate_pulse, drop_pulse, cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [2:0] cmd_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  int mq[$];
  bit m_pend[4];
  bit m_ovf;

  typedef struct {
    bit l, r, ro, d, rdy;
    int exp_valid, exp_code, exp_count, exp_ovf;
  } vec_t;

  vec_t vecs[11];

  move_command_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .rotate_pulse (rotate_pulse),
    .drop_pulse   (drop_pulse),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_count    (cmd_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending set + command queue, one prioritized enqueue per cycle.
  task automatic model_update(input bit l, r, ro, d, rdy, rs);
    bit p[4];
    int prio[4] = '{3, 2, 0, 1};
    bit do_pop, space;
    if (rs) begin
      mq.delete();
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    p = '{l, r, ro, d};
    do_pop = (mq.size() > 0) && rdy;
    space  = (mq.size() < DEPTH) || do_pop;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i] && p[i]) m_ovf = 1'b1;
      m_pend[i] = m_pend[i] | p[i];
    end
    if (do_pop) void'(mq.pop_front());
    if (space) begin
      for (int k = 0; k < 4; k++) begin
        if (m_pend[prio[k]]) begin
          mq.push_back(prio[k]);
          m_pend[prio[k]] = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_valid", int'(cmd_valid), (mq.size() != 0) ? 1 : 0);
    chk("model_code",  int'(cmd_code),  (mq.size() != 0) ? mq[0] : 0);
    chk("model_count", int'(cmd_count), mq.size());
    chk("model_ovf",   int'(overflow),  int'(m_ovf));
  endtask

  task automatic step(input bit l, r, ro, d, rdy, rs);
    left_pulse   = l;
    right_pulse  = r;
    rotate_pulse = ro;
    drop_pulse   = d;
    cmd_ready    = rdy;
    rst          = rs;
    @(posedge clk);
    #1;
    model_update(l, r, ro, d, rdy, rs);
    check_model();
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1, 1);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_code",  int'(cmd_code),  0);
    chk("rst_count", int'(cmd_count), 0);
    chk("rst_ovf",   int'(overflow),  0);
  endtask

  initial begin
    int exp32[4] = '{3, 2, 0, 1};
    int r_bias;

    vecs[0]  = '{0,0,0,0,0, 0,0,0,0};
    vecs[1]  = '{1,0,0,0,0, 1,0,1,0};
    vecs[2]  = '{0,1,0,0,0, 1,0,2,0};
    vecs[3]  = '{0,0,1,1,0, 1,0,3,0};
    vecs[4]  = '{0,0,0,0,0, 1,0,4,0};
    vecs[5]  = '{0,0,0,0,1, 1,1,3,0};
    vecs[6]  = '{1,0,0,0,1, 1,3,3,0};
    vecs[7]  = '{0,0,0,0,1, 1,2,2,0};
    vecs[8]  = '{0,0,0,0,1, 1,0,1,0};
    vecs[9]  = '{0,0,0,0,1, 0,0,0,0};
    vecs[10] = '{0,0,0,0,1, 0,0,0,0};

    rst = 1'b1;
    {left_pulse, right_pulse, rotate_pulse, drop_pulse, cmd_ready} = '0;
    do_reset();

    // Vector table
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].l, vecs[i].r, vecs[i].ro, vecs[i].d, vecs[i].rdy, 0);
      chk($sformatf("vec%0d_valid", i), int'(cmd_valid), vecs[i].exp_valid);
      chk($sformatf("vec%0d_code", i),  int'(cmd_code),  vecs[i].exp_code);
      chk($sformatf("vec%0d_count", i), int'(cmd_count), vecs[i].exp_count);
      chk($sformatf("vec%0d_ovf", i),   int'(overflow),  vecs[i].exp_ovf);
    end

    // Single press with ready already high
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("single_valid", int'(cmd_valid), 1);
    chk("single_code",  int'(cmd_code),  0);
    step(0, 0, 0, 0, 1, 0);
    chk("single_gone", int'(cmd_valid), 0);

    // Simultaneous press of all four buttons
    do_reset();
    step(1, 1, 1, 1, 0, 0);
    chk("simul_first", int'(cmd_code), 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("simul_count", int'(cmd_count), 4);
    chk("simul_ovf",   int'(overflow),  0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("simul_order%0d", i), int'(cmd_code), exp32[i]);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("simul_empty", int'(cmd_count), 0);

    // Full queue, repeated rotate press becomes overflow
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("full_cnt1", int'(cmd_count), 4);
    chk("full_ovf0", int'(overflow),  0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("full_cnt2", int'(cmd_count), 4);
    chk("full_ovf1", int'(overflow),  1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pop%0d", i), int'(cmd_code), 0);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("full_rot_code", int'(cmd_code),  2);
    chk("full_rot_cnt",  int'(cmd_count), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("full_drained", int'(cmd_valid), 0);
    chk("full_sticky",  int'(overflow),  1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("pp_count", int'(cmd_count), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_pop%0d", i), int'(cmd_code), (i == 3) ? 3 : 1);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("pp_empty", int'(cmd_count), 0);

    // Reset mid-stream with a pending press
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("mid_count", int'(cmd_count), 3);
    step(0, 0, 0, 0, 0, 1);
    chk("mid_valid", int'(cmd_valid), 0);
    chk("mid_cnt0",  int'(cmd_count), 0);
    chk("mid_ovf",   int'(overflow),  0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk($sformatf("mid_quiet%0d", i), int'(cmd_valid), 0);
    end

    // Wrap-around with alternating presses
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step((i % 2) == 0, (i % 2) == 1, 0, 0, 1, 0);
      chk($sformatf("wrap_code%0d", i), int'(cmd_code), i % 2);
      chk($sformatf("wrap_cnt%0d", i), (cmd_count <= 1) ? 1 : 0, 1);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("wrap_empty", int'(cmd_valid), 0);

    // Randomized traffic with phases of low and high drain rate
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_bias = ((i / 150) % 2 == 0) ? 20 : 80;
      step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < r_bias, $urandom_range(0, 399) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_command_queue.md
MOVE_COMMAND_QUEUE -- requirements
Module: move_command_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; legal values are powers of two, 2 to 16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 left_pulse  input  1  one-cycle press pulse from the left-button debouncer.
REQ-005 right_pulse  input  1  one-cycle press pulse from the right-button debouncer.
REQ-006 rotate_pulse  input  1  one-cycle press pulse from the rotate-button debouncer.
REQ-007 drop_pulse  input  1  one-cycle press pulse from the drop-button debouncer.
REQ-008 cmd_ready  input  1  game FSM accepts the head command this cycle.
REQ-009 cmd_valid  output  1  FIFO non-empty; the head command is presented.
REQ-010 cmd_code  output  2  head command: 0 left, 1 right, 2 rotate, 3 drop.
REQ-011 cmd_count  output  log2(DEPTH)+1  number of queued commands, 0 to DEPTH.
REQ-012 overflow  output  1  sticky flag: at least one press was lost.

Function
REQ-013 Each cycle, request vector = pending | pulse inputs, one bit per button.
REQ-014 Selection priority: drop > rotate > left > right; at most one command is enqueued per cycle.
REQ-015 Enqueue is allowed when cmd_count < DEPTH, or when cmd_count == DEPTH and a pop occurs in the same cycle.
REQ-016 When enqueue is allowed and the request vector is non-zero, the highest-priority code is written at the clock edge.
REQ-017 Pending update: next pending = request & ~selected; unselected requests carry over to later cycles.
REQ-018 A pulse for a button whose pending bit is already set merges into that bit, and overflow is set at the same edge.
REQ-019 Latency: a pulse in cycle N into an empty queue with no competing request gives cmd_valid = 1 and the matching cmd_code in cycle N+1.
REQ-020 The FIFO is first-word-fall-through: cmd_code always shows the oldest entry, and cmd_valid = (cmd_count != 0).
REQ-021 Pop occurs when cmd_valid & cmd_ready; cmd_ready while cmd_valid = 0 is ignored.
REQ-022 Push and pop in the same cycle leave cmd_count unchanged and preserve order.
REQ-023 An empty queue with a pulse and cmd_ready in the same cycle performs no pop; the command appears next cycle.
REQ-024 When full with no pop, pulses set pending bits only; pending drains in priority order as space frees.
REQ-025 Read/write pointers wrap modulo DEPTH; cmd_count never exceeds DEPTH and never underflows.
REQ-026 cmd_code is 2'b00 whenever cmd_valid = 0.
REQ-027 overflow is cleared only by rst.

Reset
REQ-028 While rst = 1 at a clock edge: pending = 0, pointers = 0, cmd_count = 0, cmd_valid = 0, cmd_code = 0, overflow = 0.
REQ-029 Pulses and cmd_ready sampled in a reset cycle are ignored.
REQ-030 Reset mid-operation discards all queued and pending commands; normal operation resumes the cycle after rst deasserts.

Verification
REQ-031 Single press: left_pulse in cycle 5, cmd_ready = 1 -> cmd_valid = 1, cmd_code = 0 in cycle 6; cmd_valid = 0 in cycle 7.
REQ-032 Simultaneous press: all four pulses in one cycle, cmd_ready = 0 -> queue holds codes 3, 2, 0, 1 in that order, cmd_count = 4 four cycles later, overflow = 0.
REQ-033 Full queue: DEPTH = 4 full, cmd_ready = 0, rotate_pulse twice 3 cycles apart -> cmd_count stays 4, overflow = 1 after the second pulse; raising cmd_ready pops 4 entries, then rotate (code 2) follows once.
REQ-034 Full with push and pop: cmd_count = 4, cmd_ready = 1 and drop_pulse in the same cycle -> cmd_count stays 4, and code 3 becomes the tail.
REQ-035 Reset mid-stream: 3 entries queued and right pending, rst pulsed 1 cycle -> next cycle cmd_valid = 0, cmd_count = 0, overflow = 0, and no command emerges afterwards.
REQ-036 Wrap-around: 10 consecutive single presses alternating left/right with cmd_ready = 1 -> output sequence 0,1,0,1,... with no loss and cmd_count never exceeding 1.
